mure_fifo_reader: RTL and testbench

MURE_FIFO_READER -- requirements
Module: mure_fifo_reader

---
 rtl/mure_fifo_reader.sv | 160 ++++++++++++++++
 tb/tb_mure_fifo_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mure_fifo_reader.sv
// Pairs uop FIFO entries with common-FIFO entries into trace packets.
// Trap-like uops wait (bounded) for their common entry before issue.
package mure_pkg;
  localparam int XLEN        = 32;
  localparam int ITYPE_LEN   = 4;
  localparam int INST_LEN    = 32;
  localparam int IRETIRE_LEN = 8;
  localparam int CAUSE_LEN   = 6;
  localparam int PRIV_LEN    = 2;

  localparam logic [ITYPE_LEN-1:0] IT_STD  = 4'd0;
  localparam logic [ITYPE_LEN-1:0] IT_EXC  = 4'd1;
  localparam logic [ITYPE_LEN-1:0] IT_INT  = 4'd2;
  localparam logic [ITYPE_LEN-1:0] IT_ERET = 4'd3;
  localparam logic [ITYPE_LEN-1:0] IT_NTB  = 4'd4;
  localparam logic [ITYPE_LEN-1:0] IT_TB   = 4'd5;

  typedef struct packed {
    logic [ITYPE_LEN-1:0]   itype;
    logic [INST_LEN-1:0]    iaddr;
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
  } uop_entry_s;

  typedef struct packed {
    logic [CAUSE_LEN-1:0] cause;
    logic [XLEN-1:0]      tval;
    logic [PRIV_LEN-1:0]  priv;
  } common_entry_s;
endpackage

module mure_fifo_reader #(
  parameter int XLEN         = mure_pkg::XLEN,
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                uop_empty_i,
  input  mure_pkg::uop_entry_s                uop_entry_i,
  output logic                                uop_pop_o,
  input  logic                                common_empty_i,
  input  mure_pkg::common_entry_s             common_entry_i,
  output logic                                common_pop_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output logic [mure_pkg::ITYPE_LEN-1:0]      itype_o,
  output logic [mure_pkg::INST_LEN-1:0]       iaddr_o,
  output logic [mure_pkg::IRETIRE_LEN-1:0]    iretire_o,
  output logic                                ilastsize_o,
  output logic [mure_pkg::CAUSE_LEN-1:0]      cause_o,
  output logic [XLEN-1:0]                     tval_o,
  output logic [mure_pkg::PRIV_LEN-1:0]       priv_o,
  output logic                                err_o
);
  import mure_pkg::*;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT_C,
    S_FULL
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(WAIT_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q;
  logic       need_c, take;
  logic       pop_u, pop_c;
  logic       ld_uop, ld_com, ld_zero;
  logic       cnt_clr, cnt_inc, tmo;

  assign need_c = uop_entry_i.itype inside {IT_EXC, IT_INT, IT_ERET};
  assign take   = (state_q == S_EMPTY) ||
                  (state_q == S_FULL && ready_i);

  always_comb begin
    state_d = state_q;
    pop_u   = 1'b0;
    pop_c   = 1'b0;
    ld_uop  = 1'b0;
    ld_com  = 1'b0;
    ld_zero = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    tmo     = 1'b0;
    unique case (1'b1)
      take: begin
        state_d = S_EMPTY;
        if (!uop_empty_i) begin
          pop_u  = 1'b1;
          ld_uop = 1'b1;
          if (!need_c) begin
            ld_zero = 1'b1;
            state_d = S_FULL;
          end else if (!common_empty_i) begin
            pop_c   = 1'b1;
            ld_com  = 1'b1;
            state_d = S_FULL;
          end else begin
            cnt_clr = 1'b1;
            state_d = S_WAIT_C;
          end
        end
      end
      (state_q == S_WAIT_C): begin
        if (!common_empty_i) begin
          pop_c   = 1'b1;
          ld_com  = 1'b1;
          state_d = S_FULL;
        end else if (cnt_q >= CNT_LAST) begin
          tmo     = 1'b1;
          ld_zero = 1'b1;
          state_d = S_FULL;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Pops are suppressed during reset so no entry is lost to the flush.
  assign uop_pop_o    = pop_u & ~rst_i;
  assign common_pop_o = pop_c & ~rst_i;
  assign valid_o      = (state_q == S_FULL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_EMPTY;
      cnt_q       <= '0;
      itype_o     <= '0;
      iaddr_o     <= '0;
      iretire_o   <= '0;
      ilastsize_o <= 1'b0;
      cause_o     <= '0;
      tval_o      <= '0;
      priv_o      <= 2'b11;
      err_o       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cnt_clr) cnt_q <= '0;
      else if (cnt_inc) cnt_q <= cnt_q + 8'd1;
      if (ld_uop) begin
        itype_o     <= uop_entry_i.itype;
        iaddr_o     <= uop_entry_i.iaddr;
        iretire_o   <= uop_entry_i.iretire;
        ilastsize_o <= uop_entry_i.ilastsize;
      end
      if (ld_com) begin
        cause_o <= common_entry_i.cause;
        tval_o  <= XLEN'(common_entry_i.tval);
        priv_o  <= common_entry_i.priv;
      end else if (ld_zero) begin
        cause_o <= '0;
        tval_o  <= '0;
      end
      if (tmo) err_o <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mure_fifo_reader.sv
// Directed bench for mure_fifo_reader: two instances, default
// timeout and a short timeout of 4, share one stimulus stream.
module tb_mure_fifo_reader;
  import mure_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic uop_empty, common_empty, ready;
  uop_entry_s    uop;
  common_entry_s com;

  logic         upop, cpop, valid, ilast, err;
  logic [3:0]   itype;
  logic [31:0]  iaddr, tval;
  logic [7:0]   iret;
  logic [5:0]   cause;
  logic [1:0]   priv;

  logic         upop_b, cpop_b, valid_b, ilast_b, err_b;
  logic [3:0]   itype_b;
  logic [31:0]  iaddr_b, tval_b;
  logic [7:0]   iret_b;
  logic [5:0]   cause_b;
  logic [1:0]   priv_b;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  mure_fifo_reader dut (
    .clk_i(clk), .rst_i(rst),
    .uop_empty_i(uop_empty), .uop_entry_i(uop), .uop_pop_o(upop),
    .common_empty_i(common_empty), .common_entry_i(com),
    .common_pop_o(cpop), .valid_o(valid), .ready_i(ready),
    .itype_o(itype), .iaddr_o(iaddr), .iretire_o(iret),
    .ilastsize_o(ilast), .cause_o(cause), .tval_o(tval),
    .priv_o(priv), .err_o(err)
  );

  mure_fifo_reader #(.WAIT_TIMEOUT(4)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .uop_empty_i(uop_empty), .uop_entry_i(uop), .uop_pop_o(upop_b),
    .common_empty_i(common_empty), .common_entry_i(com),
    .common_pop_o(cpop_b), .valid_o(valid_b), .ready_i(ready),
    .itype_o(itype_b), .iaddr_o(iaddr_b), .iretire_o(iret_b),
    .ilastsize_o(ilast_b), .cause_o(cause_b), .tval_o(tval_b),
    .priv_o(priv_b), .err_o(err_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_uop(input logic [3:0] t, input logic [31:0] a,
                         input logic [7:0] r, input logic l);
    uop.itype     = t;
    uop.iaddr     = a;
    uop.iretire   = r;
    uop.ilastsize = l;
  endtask

  task automatic burst(input bit toggle, input logic [31:0] base,
                       output int got, output int ncyc);
    int idx = 0;
    bit held = 0;
    logic [31:0] haddr = '0;
    bit pop;
    got  = 0;
    ncyc = 0;
    while (got < 10 && ncyc < 60) begin
      uop_empty = (idx >= 10);
      set_uop(IT_STD, base + 32'(idx * 4), 8'd1, 1'b0);
      ready = toggle ? ~ncyc[0] : 1'b1;
      settle();
      if (held) begin
        chk("hold_valid", {63'd0, valid}, 64'd1);
        chk("hold_addr", {32'd0, iaddr}, {32'd0, haddr});
      end
      held = valid && !ready;
      haddr = iaddr;
      if (valid && ready) begin
        chk("pkt_addr", {32'd0, iaddr}, {32'd0, base + 32'(got * 4)});
        got++;
      end
      pop = upop;
      cyc();
      if (pop) idx++;
      ncyc++;
    end
    uop_empty = 1'b1;
    ready = 1'b1;
  endtask

  initial begin
    int got, ncyc;
    rst = 1'b1;
    uop_empty = 1'b0;
    common_empty = 1'b0;
    ready = 1'b1;
    set_uop(IT_TB, 32'h1000, 8'd2, 1'b1);
    com = '{cause: 6'd2, tval: 32'hDEAD, priv: 2'd1};
    cyc();
    cyc();
    settle();
    chk("rst_valid", {63'd0, valid}, 64'd0);
    chk("rst_priv", {62'd0, priv}, 64'd3);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_iaddr", {32'd0, iaddr}, 64'd0);
    chk("rst_upop", {63'd0, upop}, 64'd0);
    chk("rst_cpop", {63'd0, cpop}, 64'd0);

    // plain uop, no common
    rst = 1'b0;
    common_empty = 1'b1;
    cyc();
    settle();
    chk("std_upop", {63'd0, upop}, 64'd1);
    chk("std_cpop", {63'd0, cpop}, 64'd0);
    cyc();
    uop_empty = 1'b1;
    settle();
    chk("std_valid", {63'd0, valid}, 64'd1);
    chk("std_itype", {60'd0, itype}, {60'd0, IT_TB});
    chk("std_iaddr", {32'd0, iaddr}, 64'h1000);
    chk("std_iret", {56'd0, iret}, 64'd2);
    chk("std_ilast", {63'd0, ilast}, 64'd1);
    chk("std_cause", {58'd0, cause}, 64'd0);
    chk("std_tval", {32'd0, tval}, 64'd0);
    chk("std_priv", {62'd0, priv}, 64'd3);
    chk("std_upop2", {63'd0, upop}, 64'd0);
    cyc();
    settle();
    chk("std_drain", {63'd0, valid}, 64'd0);

    // exception with common ready
    set_uop(IT_EXC, 32'h2000, 8'd1, 1'b0);
    uop_empty = 1'b0;
    common_empty = 1'b0;
    settle();
    chk("exc_upop", {63'd0, upop}, 64'd1);
    chk("exc_cpop", {63'd0, cpop}, 64'd1);
    cyc();
    uop_empty = 1'b1;
    common_empty = 1'b1;
    settle();
    chk("exc_valid", {63'd0, valid}, 64'd1);
    chk("exc_itype", {60'd0, itype}, {60'd0, IT_EXC});
    chk("exc_iaddr", {32'd0, iaddr}, 64'h2000);
    chk("exc_cause", {58'd0, cause}, 64'd2);
    chk("exc_tval", {32'd0, tval}, 64'hDEAD);
    chk("exc_priv", {62'd0, priv}, 64'd1);
    cyc();

    // interrupt, common arrives 5 cycles late
    set_uop(IT_INT, 32'h3000, 8'd1, 1'b0);
    uop_empty = 1'b0;
    settle();
    chk("int_upop", {63'd0, upop}, 64'd1);
    chk("int_cpop0", {63'd0, cpop}, 64'd0);
    cyc();
    uop_empty = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("int_wait_valid", {63'd0, valid}, 64'd0);
      chk("int_wait_cpop", {63'd0, cpop}, 64'd0);
      chk("int_wait_upop", {63'd0, upop}, 64'd0);
      cyc();
    end
    com = '{cause: 6'd7, tval: 32'h0, priv: 2'd3};
    common_empty = 1'b0;
    settle();
    chk("int_cpop5", {63'd0, cpop}, 64'd1);
    chk("int_valid5", {63'd0, valid}, 64'd0);
    cyc();
    common_empty = 1'b1;
    settle();
    chk("int_valid6", {63'd0, valid}, 64'd1);
    chk("int_itype", {60'd0, itype}, {60'd0, IT_INT});
    chk("int_cause", {58'd0, cause}, 64'd7);
    chk("int_priv", {62'd0, priv}, 64'd3);
    chk("int_err", {63'd0, err}, 64'd0);
    cyc();

    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // timeout on the short-timeout instance
    set_uop(IT_EXC, 32'h4000, 8'd1, 1'b0);
    uop_empty = 1'b0;
    settle();
    chk("tmo_upop", {63'd0, upop_b}, 64'd1);
    cyc();
    uop_empty = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      settle();
      chk("tmo_wait_valid", {63'd0, valid_b}, 64'd0);
      chk("tmo_wait_err", {63'd0, err_b}, 64'd0);
      cyc();
    end
    ready = 1'b0;
    settle();
    chk("tmo_valid", {63'd0, valid_b}, 64'd1);
    chk("tmo_cause", {58'd0, cause_b}, 64'd0);
    chk("tmo_tval", {32'd0, tval_b}, 64'd0);
    chk("tmo_iaddr", {32'd0, iaddr_b}, 64'h4000);
    chk("tmo_err", {63'd0, err_b}, 64'd1);
    chk("tmo_err_long", {63'd0, err}, 64'd0);
    cyc();
    cyc();
    settle();
    chk("tmo_hold", {63'd0, valid_b}, 64'd1);
    chk("tmo_sticky", {63'd0, err_b}, 64'd1);

    // reset while FULL-held (b) and WAIT_C (default instance)
    rst = 1'b1;
    uop_empty = 1'b0;
    common_empty = 1'b0;
    settle();
    chk("rstw_upop", {63'd0, upop}, 64'd0);
    chk("rstw_cpop", {63'd0, cpop}, 64'd0);
    chk("rstw_cpop_b", {63'd0, cpop_b}, 64'd0);
    cyc();
    settle();
    chk("rstw_valid", {63'd0, valid}, 64'd0);
    chk("rstw_valid_b", {63'd0, valid_b}, 64'd0);
    chk("rstw_priv_b", {62'd0, priv_b}, 64'd3);
    chk("rstw_err_b", {63'd0, err_b}, 64'd0);
    rst = 1'b0;
    uop_empty = 1'b1;
    common_empty = 1'b1;
    ready = 1'b1;
    cyc();

    burst(1'b1, 32'h5000, got, ncyc);
    chk("toggle_count", 64'(got), 64'd10);
    cyc();
    settle();
    chk("toggle_drain", {63'd0, valid}, 64'd0);

    burst(1'b0, 32'h6000, got, ncyc);
    chk("thru_count", 64'(got), 64'd10);
    chk("thru_cycles", 64'(ncyc), 64'd11);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
